// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered ALU between two requesters.
// Every output is registered; the requests only steer the next-state and load logic.
module alu_share_arbiter #(
   parameter int DW      = 3,
   parameter int ALU_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              req1,
   input  logic [DW-1:0]     a0,
   input  logic [DW-1:0]     b0,
   input  logic [DW-1:0]     a1,
   input  logic [DW-1:0]     b1,
   input  logic [1:0]        op0,
   input  logic [1:0]        op1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [2*DW-1:0]   dout,
   output logic              busy,
   output logic              alu_en,
   output logic [1:0]        alu_op,
   output logic [DW-1:0]     alu_A,
   output logic [DW-1:0]     alu_B,
   input  logic [2*DW-1:0]   alu_dout
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t     state, state_nx;
   logic       ptr;
   logic       id;
   logic       win;
   logic [2:0] cnt;

   // ptr names the requester that wins a tie; a lone request always wins
   always_comb begin
      win = req1;
      if (req0 && req1) win = ptr;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req0 || req1) state_nx = ISSUE;
         ISSUE:   state_nx = WAIT;
         WAIT:    if (cnt == 3'd1) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt0   <= 1'b0;
         gnt1   <= 1'b0;
         done0  <= 1'b0;
         done1  <= 1'b0;
         busy   <= 1'b0;
         alu_en <= 1'b0;
         alu_op <= '0;
         alu_A  <= '0;
         alu_B  <= '0;
         dout   <= '0;
         ptr    <= 1'b0;
         id     <= 1'b0;
         cnt    <= '0;
      end else begin
         gnt0   <= 1'b0;
         gnt1   <= 1'b0;
         done0  <= 1'b0;
         done1  <= 1'b0;
         alu_en <= 1'b0;
         busy   <= (state_nx != IDLE);
         case (state)
            IDLE: begin
               // grant, operand latch and ALU enable all land in the ISSUE cycle
               if (req0 || req1) begin
                  id     <= win;
                  gnt0   <= ~win;
                  gnt1   <= win;
                  alu_en <= 1'b1;
                  alu_op <= win ? op1 : op0;
                  alu_A  <= win ? a1  : a0;
                  alu_B  <= win ? b1  : b0;
               end
            end
            ISSUE: cnt <= 3'(ALU_LAT);
            WAIT: begin
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1) begin
                  dout  <= alu_dout;
                  done0 <= ~id;
                  done1 <= id;
               end
            end
            DONE:    ptr <= ~id;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: one instance with ALU_LAT=1, one with ALU_LAT=3,
// each driving a registered ALU stub that returns {000, ~(A^B)}.
module tb_alu_share_arbiter;

   localparam int DW = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          req0, req1, gnt0, gnt1, done0, done1, busy, alu_en;
   logic [DW-1:0] a0, b0, a1, b1, alu_A, alu_B;
   logic [1:0]    op0, op1, alu_op;
   logic [5:0]    dout, alu_dout;

   logic          req0_3, req1_3, gnt0_3, gnt1_3, done0_3, done1_3, busy_3, alu_en_3;
   logic [DW-1:0] a0_3, b0_3, a1_3, b1_3, alu_A_3, alu_B_3;
   logic [1:0]    op0_3, op1_3, alu_op_3;
   logic [5:0]    dout_3, alu_dout_3;

   alu_share_arbiter #(.DW(DW), .ALU_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
      .a0(a0), .b0(b0), .a1(a1), .b1(b1), .op0(op0), .op1(op1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .dout(dout),
      .busy(busy), .alu_en(alu_en), .alu_op(alu_op), .alu_A(alu_A), .alu_B(alu_B),
      .alu_dout(alu_dout));

   alu_share_arbiter #(.DW(DW), .ALU_LAT(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req0(req0_3), .req1(req1_3),
      .a0(a0_3), .b0(b0_3), .a1(a1_3), .b1(b1_3), .op0(op0_3), .op1(op1_3),
      .gnt0(gnt0_3), .gnt1(gnt1_3), .done0(done0_3), .done1(done1_3), .dout(dout_3),
      .busy(busy_3), .alu_en(alu_en_3), .alu_op(alu_op_3), .alu_A(alu_A_3), .alu_B(alu_B_3),
      .alu_dout(alu_dout_3));

   // ALU stubs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      alu_dout <= '0;
      else if (alu_en) alu_dout <= {3'b000, ~(alu_A ^ alu_B)};
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        alu_dout_3 <= '0;
      else if (alu_en_3) alu_dout_3 <= {3'b000, ~(alu_A_3 ^ alu_B_3)};
   end

   int checks = 0;
   int errors = 0;
   logic [5:0] q0[$], q1[$], q3[$];
   int gnt1_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [5:0] exp_res(input logic [2:0] a, input logic [2:0] b);
      return {3'b000, ~(a ^ b)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; req0_3 = 1'b0; req1_3 = 1'b0;
      q0.delete(); q1.delete(); q3.delete();
      repeat (2) step();
      rst_n = 1'b1;
      step();
   endtask

   // scoreboard monitors
   always @(negedge clk) begin
      if (rst_n) begin
         if (gnt1) gnt1_cnt++;
         if (gnt0 && gnt1) check("gnt_excl", 32'(gnt0 & gnt1), 0);
         if (done0 || done1) begin
            check("done_excl", 32'(done0 & done1), 0);
            if (done0) begin
               check("sb0_pending", 32'(q0.size() != 0), 1);
               if (q0.size() != 0) check("sb0_dout", 32'(dout), 32'(q0.pop_front()));
            end
            if (done1) begin
               check("sb1_pending", 32'(q1.size() != 0), 1);
               if (q1.size() != 0) check("sb1_dout", 32'(dout), 32'(q1.pop_front()));
            end
         end
         if (done1_3) begin
            check("sb3_pending", 32'(q3.size() != 0), 1);
            if (q3.size() != 0) check("sb3_dout", 32'(dout_3), 32'(q3.pop_front()));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int ng;
      int g1;
      rst_n = 1'b0;
      req0 = 0; req1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0; op0 = 0; op1 = 0;
      req0_3 = 0; req1_3 = 0; a0_3 = 0; b0_3 = 0; a1_3 = 0; b1_3 = 0; op0_3 = 0; op1_3 = 0;
      step();
      check("rst_gnt",   32'({gnt0, gnt1}), 0);
      check("rst_done",  32'({done0, done1}), 0);
      check("rst_busy",  32'(busy), 0);
      check("rst_alu",   32'({alu_en, alu_op, alu_A, alu_B}), 0);
      check("rst_dout",  32'(dout), 0);
      do_reset();

      // single transaction
      a0 = 3'b011; b0 = 3'b001; op0 = 2'b00; req0 = 1'b1;
      q0.push_back(exp_res(3'b011, 3'b001));
      for (int c = 1; c <= 4; c++) begin
         step();
         check("t1_gnt0",  32'(gnt0), 32'(c == 1));
         check("t1_alu_en", 32'(alu_en), 32'(c == 1));
         check("t1_busy",  32'(busy), 32'(c <= 3));
         check("t1_done0", 32'(done0), 32'(c == 3));
         if (c == 1) check("t1_alu_ab", 32'({alu_A, alu_B}), 32'({3'b011, 3'b001}));
         if (c == 3) check("t1_dout", 32'(dout), 32'(6'b000101));
         if (gnt0) req0 = 1'b0;
      end

      // simultaneous requests after reset
      do_reset();
      a1 = 3'b110; b1 = 3'b110; op1 = 2'b01;
      req0 = 1'b1; req1 = 1'b1;
      q0.push_back(exp_res(a0, b0));
      q1.push_back(exp_res(3'b110, 3'b110));
      for (int c = 1; c <= 8; c++) begin
         step();
         check("t2_gnt0",  32'(gnt0), 32'(c == 1));
         check("t2_gnt1",  32'(gnt1), 32'(c == 5));
         check("t2_done0", 32'(done0), 32'(c == 3));
         check("t2_done1", 32'(done1), 32'(c == 7));
         check("t2_busy",  32'(busy), 32'(c != 4 && c != 8));
         if (c == 7) check("t2_dout", 32'(dout), 32'(6'b000111));
         if (gnt0) req0 = 1'b0;
         if (gnt1) req1 = 1'b0;
      end

      // fairness with both requests held
      do_reset();
      a0 = 3'b100; b0 = 3'b001; a1 = 3'b010; b1 = 3'b111;
      repeat (2) begin
         q0.push_back(exp_res(3'b100, 3'b001));
         q1.push_back(exp_res(3'b010, 3'b111));
      end
      req0 = 1'b1; req1 = 1'b1;
      ng = 0;
      for (int c = 1; c <= 24 && ng < 4; c++) begin
         step();
         if (gnt0 || gnt1) begin
            check("t3_cycle", 32'(c), 32'(4 * ng + 1));
            check("t3_id", 32'(gnt1), 32'(ng % 2));
            ng++;
            if (ng == 4) begin req0 = 1'b0; req1 = 1'b0; end
         end
      end
      check("t3_grants", 32'(ng), 4);
      repeat (4) step();
      check("t3_drain", 32'(q0.size() + q1.size()), 0);

      // ALU_LAT=3: first transaction leaves a nonzero dout behind
      do_reset();
      for (int t = 0; t < 2; t++) begin
         a1_3 = (t == 0) ? 3'b001 : 3'b111;
         b1_3 = (t == 0) ? 3'b001 : 3'b000;
         q3.push_back(exp_res(a1_3, b1_3));
         req1_3 = 1'b1;
         for (int c = 1; c <= 6; c++) begin
            step();
            check("t4_gnt1",   32'(gnt1_3), 32'(c == 1));
            check("t4_alu_en", 32'(alu_en_3), 32'(c == 1));
            check("t4_done1",  32'(done1_3), 32'(c == 5));
            check("t4_busy",   32'(busy_3), 32'(c <= 5));
            if (c == 5) check("t4_dout", 32'(dout_3), (t == 0) ? 32'(6'b000111) : 32'(6'b000000));
            if (gnt1_3) req1_3 = 1'b0;
         end
      end

      // reset mid-operation
      do_reset();
      a0 = 3'b011; b0 = 3'b001; op0 = 2'b11;
      q0.push_back(exp_res(3'b011, 3'b001));
      req0 = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         step();
         if (gnt0) req0 = 1'b0;
      end
      a0 = 3'b010; b0 = 3'b000;
      q0.push_back(exp_res(3'b010, 3'b000));
      req0 = 1'b1;
      step();
      req0 = 1'b0;
      step();
      check("t5_in_wait", 32'(busy & ~alu_en), 1);
      rst_n = 1'b0;
      q0.delete();
      #1;
      check("t5_rst_ctl",  32'({gnt0, gnt1, done0, done1, busy, alu_en}), 0);
      check("t5_rst_alu",  32'({alu_op, alu_A, alu_B}), 0);
      check("t5_rst_dout", 32'(dout), 0);
      step();
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check("t5_no_done", 32'({done0, done1}), 0);
      end
      a1 = 3'b101; b1 = 3'b100;
      q0.push_back(exp_res(a0, b0));
      q1.push_back(exp_res(3'b101, 3'b100));
      req0 = 1'b1; req1 = 1'b1;
      step();
      check("t5_ptr_gnt0", 32'(gnt0), 1);
      check("t5_ptr_gnt1", 32'(gnt1), 0);
      req0 = 1'b0;
      ng = 0;
      for (int c = 0; c < 10 && ng == 0; c++) begin
         step();
         if (gnt1) begin ng = 1; req1 = 1'b0; end
      end
      check("t5_second_gnt1", 32'(ng), 1);
      repeat (4) step();
      q1.push_back(exp_res(3'b101, 3'b100));
      req1 = 1'b1;
      step();
      check("t5_lone_gnt1", 32'(gnt1), 1);
      check("t5_lone_gnt0", 32'(gnt0), 0);
      req1 = 1'b0;
      repeat (4) step();

      // lost request pulse, operand change after grant
      do_reset();
      a0 = 3'b010; b0 = 3'b011; op0 = 2'b01;
      q0.push_back(6'b000110);
      g1 = gnt1_cnt;
      req0 = 1'b1;
      step();
      check("t6_gnt0", 32'(gnt0), 1);
      req0 = 1'b0; req1 = 1'b1; a0 = 3'b111;
      step();
      req1 = 1'b0;
      repeat (8) step();
      check("t6_no_gnt1", 32'(gnt1_cnt), 32'(g1));
      check("t6_dout_hold", 32'(dout), 32'(6'b000110));

      check("sb_drain", 32'(q0.size() + q1.size() + q3.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
